// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two writeback ports (B over A), optional
// write-to-read bypass and a per-register busy scoreboard for issue/writeback tracking.
module regfile_mp_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ack,
    input  logic                sb_flush,
    output logic                wr_conflict,
    output logic [AW:0]         busy_cnt
);
    // Storage covers the full address space; slots >= NREG are never written or reserved.
    localparam int unsigned NSLOT = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < CW'(NREG);
    endfunction

    logic [XLEN-1:0]  mem [NSLOT];
    logic [NSLOT-1:0] busy;
    logic [NSLOT-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             wa_ok;
    logic             wb_ok;
    logic             rsv_set;

    assign wa_ok   = wa_en && in_range(wa_addr) && (wa_addr != '0);
    assign wb_ok   = wb_en && in_range(wb_addr) && (wb_addr != '0);
    // Acceptance looks at the current busy bit, so a same-cycle writeback does not free it yet.
    assign rsv_ack = rsv_en && !sb_flush && in_range(rsv_addr)
                     && ((rsv_addr == '0) || !busy[rsv_addr]);
    assign rsv_set = rsv_ack && (rsv_addr != '0);

    // Scoreboard next state: flush, then new reservation, then writeback clear.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int r = 0; r < int'(NSLOT); r++) begin
            if (sb_flush) begin
                busy_nxt[r] = 1'b0;
            end else if (rsv_set && (rsv_addr == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if ((wa_ok && (wa_addr == AW'(r))) || (wb_ok && (wb_addr == AW'(r)))) begin
                busy_nxt[r] = 1'b0;
            end
            cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NSLOT); r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(NSLOT); r++) begin
                if (wb_ok && (wb_addr == AW'(r))) begin
                    mem[r] <= wb_data;
                end else if (wa_ok && (wa_addr == AW'(r))) begin
                    mem[r] <= wa_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            busy_cnt    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            busy_cnt    <= cnt_nxt;
            wr_conflict <= wa_ok && wb_ok && (wa_addr == wb_addr);
        end
    end

    // Combinational read ports with optional forwarding of this cycle's write.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            if (in_range(rd_addr[k*AW +: AW]) && (rd_addr[k*AW +: AW] != '0)) begin
                if ((BYPASS != 0) && wb_ok && (wb_addr == rd_addr[k*AW +: AW])) begin
                    rd_data[k*XLEN +: XLEN] = wb_data;
                end else if ((BYPASS != 0) && wa_ok && (wa_addr == rd_addr[k*AW +: AW])) begin
                    rd_data[k*XLEN +: XLEN] = wa_data;
                end else begin
                    rd_data[k*XLEN +: XLEN] = mem[rd_addr[k*AW +: AW]];
                    rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
                end
            end
        end
    end

endmodule
